// File: rtl/data_sram_like_responder_if.sv
// Data-side SRAM-like bus between the MEM-stage initiator and a memory responder.
// Signals:
//   req/wr/size/wstrb/addr/wdata  initiator -> responder request fields
//   addr_ok                       responder accepts the request this cycle
//   data_ok/rdata                 one-cycle completion of the oldest transaction
// Modports: master (initiator side), slave (responder side).
interface data_sram_like_responder_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/data_sram_like_responder.sv
// Responder end of the data-side SRAM-like interface, backed by an internal
// word-organised memory. Requests are accepted after a programmable hold time
// and answered in order after a programmable latency, with a bounded number of
// transactions in flight.
// Ports:
//   clk    clock
//   reset  synchronous, active-high; empties the queue, memory is kept
//   bus    slave modport: req/wr/size/wstrb/addr/wdata in,
//          addr_ok (combinational accept), data_ok/rdata (registered) out
module data_sram_like_responder #(
  parameter int MEM_AW      = 14,
  parameter int ADDR_DELAY  = 0,
  parameter int DATA_DELAY  = 1,
  parameter int OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  data_sram_like_responder_if.slave bus
);

  localparam int CW = $clog2(OUTSTANDING + 1);
  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int WW = (ADDR_DELAY > 0) ? $clog2(ADDR_DELAY + 1) : 1;

  logic [31:0] mem [2**MEM_AW];

  // Queue of in-flight transactions, circular over OUTSTANDING slots.
  logic [OUTSTANDING-1:0] ent_vld_q, ent_vld_d;
  logic [OUTSTANDING-1:0] ent_rd_q,  ent_rd_d;
  logic [3:0]             ent_cnt_q [OUTSTANDING];
  logic [3:0]             ent_cnt_d [OUTSTANDING];
  logic [31:0]            ent_dat_q [OUTSTANDING];
  logic [31:0]            ent_dat_d [OUTSTANDING];
  logic [PW-1:0]          head_q, head_d;
  logic [PW-1:0]          tail_q, tail_d;
  logic [CW-1:0]          count_q, count_d;
  logic [WW-1:0]          wait_q, wait_d;
  logic                   data_ok_q, data_ok_d;
  logic [31:0]            rdata_q, rdata_d;

  logic [MEM_AW-1:0]      mem_idx;
  logic [31:0]            rd_word;
  logic                   pop;
  logic                   accept;

  logic unused_bits;
  assign unused_bits = ^{bus.size, bus.addr[31:MEM_AW+2], bus.addr[1:0]};

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign mem_idx = bus.addr[MEM_AW+1:2];

  always_comb begin
    rd_word = mem[mem_idx];
  end

  // data_ok_q is high exactly when the head is completing, so it doubles as
  // the pop strobe and frees a slot for a same-cycle accept when full.
  assign pop    = data_ok_q;
  assign accept = bus.req && !reset
                && (wait_q == WW'(ADDR_DELAY))
                && ((count_q < CW'(OUTSTANDING)) || pop);

  assign bus.addr_ok = accept;
  assign bus.data_ok = data_ok_q;
  assign bus.rdata   = rdata_q;

  always_comb begin
    ent_vld_d = ent_vld_q;
    ent_rd_d  = ent_rd_q;
    ent_cnt_d = ent_cnt_q;
    ent_dat_d = ent_dat_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;

    for (int unsigned i = 0; i < OUTSTANDING; i++) begin
      if (ent_vld_q[i] && (ent_cnt_q[i] != 4'd0)) begin
        ent_cnt_d[i] = ent_cnt_q[i] - 4'd1;
      end
    end

    if (pop) begin
      ent_vld_d[head_q] = 1'b0;
      head_d            = ptr_inc(head_q);
    end

    // Push after pop: when full, tail == head and the freed slot is reused.
    if (accept) begin
      ent_vld_d[tail_q] = 1'b1;
      ent_rd_d[tail_q]  = !bus.wr;
      ent_cnt_d[tail_q] = 4'(DATA_DELAY - 1);
      ent_dat_d[tail_q] = bus.wr ? '0 : rd_word;
      tail_d            = ptr_inc(tail_q);
    end

    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Outputs are registered from the next queue state so that data_ok is
    // high in the same cycle the head reaches zero.
    data_ok_d = ent_vld_d[head_d] && (ent_cnt_d[head_d] == 4'd0);
    rdata_d   = (data_ok_d && ent_rd_d[head_d]) ? ent_dat_d[head_d] : '0;

    if (!bus.req || accept) begin
      wait_d = '0;
    end else if (wait_q == WW'(ADDR_DELAY)) begin
      wait_d = wait_q;
    end else begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ent_vld_q <= '0;
      ent_rd_q  <= '0;
      for (int unsigned i = 0; i < OUTSTANDING; i++) begin
        ent_cnt_q[i] <= '0;
        ent_dat_q[i] <= '0;
      end
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      wait_q    <= '0;
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      ent_vld_q <= ent_vld_d;
      ent_rd_q  <= ent_rd_d;
      ent_cnt_q <= ent_cnt_d;
      ent_dat_q <= ent_dat_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      wait_q    <= wait_d;
      data_ok_q <= data_ok_d;
      rdata_q   <= rdata_d;
    end
  end

  // Memory has no reset; accepted writes survive a reset.
  always_ff @(posedge clk) begin
    if (accept && bus.wr) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (bus.wstrb[b]) begin
          mem[mem_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_sram_like_responder.sv
// Bench for data_sram_like_responder: four instances with different
// delay/latency/depth settings, driven one at a time. A transaction-level
// model predicts accept cycles, completion cycles and read data.
module tb_data_sram_like_responder;

  localparam int NI = 4;
  localparam int AD_T [NI] = '{0, 2, 0, 0};
  localparam int DD_T [NI] = '{1, 1, 3, 4};
  localparam int OS_T [NI] = '{2, 2, 2, 4};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req_a   [NI];
  logic        wr_a    [NI];
  logic [1:0]  size_a  [NI];
  logic [3:0]  strb_a  [NI];
  logic [31:0] addr_a  [NI];
  logic [31:0] wdata_a [NI];
  logic        aok_a   [NI];
  logic        dok_a   [NI];
  logic [31:0] rd_a    [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    data_sram_like_responder_if bus ();
    assign bus.req   = req_a[g];
    assign bus.wr    = wr_a[g];
    assign bus.size  = size_a[g];
    assign bus.wstrb = strb_a[g];
    assign bus.addr  = addr_a[g];
    assign bus.wdata = wdata_a[g];
    assign aok_a[g]  = bus.addr_ok;
    assign dok_a[g]  = bus.data_ok;
    assign rd_a[g]   = bus.rdata;
    data_sram_like_responder #(
      .MEM_AW(14), .ADDR_DELAY(AD_T[g]), .DATA_DELAY(DD_T[g]), .OUTSTANDING(OS_T[g])
    ) u_dut (
      .clk(clk), .reset(reset), .bus(bus)
    );
  end

  int chk_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int held = 0;
  int due_q [$];
  logic [31:0] dat_q [$];
  logic [31:0] mmem [int];
  bit obs_aok;
  logic [31:0] last_rd = '0;
  int dok_cnt = 0;
  int dok_cyc [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    assert (got === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int dc(input int i);
    return (dok_cyc.size() > i) ? dok_cyc[i] : -1;
  endfunction

  // One clock cycle for instance k: predict, compare, advance the model.
  task automatic tick(input int k);
    bit edok, eaok;
    logic [31:0] erd, w;
    int due, key;
    @(negedge clk);
    edok = (due_q.size() > 0) && (due_q[0] == cyc);
    erd  = edok ? dat_q[0] : 32'h0;
    eaok = req_a[k] && !reset && (held >= AD_T[k])
         && ((due_q.size() < OS_T[k]) || edok);
    check($sformatf("addr_ok[%0d]@%0d", k, cyc), {31'b0, aok_a[k]}, {31'b0, eaok});
    check($sformatf("data_ok[%0d]@%0d", k, cyc), {31'b0, dok_a[k]}, {31'b0, edok});
    check($sformatf("rdata[%0d]@%0d", k, cyc), rd_a[k], erd);
    obs_aok = (aok_a[k] === 1'b1);
    if (dok_a[k] === 1'b1) begin
      last_rd = rd_a[k];
      dok_cnt++;
      dok_cyc.push_back(cyc);
    end
    if (edok) begin
      void'(due_q.pop_front());
      void'(dat_q.pop_front());
    end
    if (reset) begin
      due_q.delete();
      dat_q.delete();
      held = 0;
    end else begin
      if (eaok) begin
        key = k * 65536 + int'(addr_a[k][15:2]);
        w = mmem.exists(key) ? mmem[key] : 32'h0;
        if (wr_a[k]) begin
          for (int b = 0; b < 4; b++)
            if (strb_a[k][b]) w[8*b +: 8] = wdata_a[k][8*b +: 8];
          mmem[key] = w;
          w = 32'h0;
        end
        due = cyc + DD_T[k];
        if (due_q.size() > 0 && due_q[$] + 1 > due) due = due_q[$] + 1;
        due_q.push_back(due);
        dat_q.push_back(w);
      end
      if (req_a[k] && !eaok) begin
        if (held < AD_T[k]) held = held + 1;
      end else begin
        held = 0;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold it until accepted; leaves req high.
  task automatic issue(input int k, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s, output int acc);
    req_a[k] = 1'b1; wr_a[k] = w; addr_a[k] = a; wdata_a[k] = d;
    strb_a[k] = s; size_a[k] = 2'd2;
    acc = -1;
    for (int n = 0; n < 40; n++) begin
      tick(k);
      if (obs_aok) begin
        acc = cyc - 1;
        break;
      end
    end
    chk_cnt++;
    assert (acc >= 0) else begin
      err_cnt++;
      $error("FAIL accept_timeout[%0d]: observed no addr_ok, expected one within 40 cycles", k);
    end
  endtask

  task automatic idle(input int k, input int n);
    req_a[k] = 1'b0;
    repeat (n) tick(k);
  endtask

  task automatic rand_phase(input int k, input int n);
    int a;
    logic [31:0] ad;
    for (int i = 0; i < 16; i++) issue(k, 1'b1, 32'h200 + 32'(4 * i), $urandom, 4'hF, a);
    for (int i = 0; i < n; i++) begin
      ad = {16'($urandom), 16'h0200 + 16'($urandom_range(0, 15) * 4 + $urandom_range(0, 3))};
      issue(k, 1'($urandom_range(0, 1)), ad, $urandom, 4'($urandom_range(0, 15)), a);
      if ($urandom_range(0, 3) == 0) idle(k, $urandom_range(1, 3));
    end
    idle(k, 8);
  endtask

  initial begin
    int a1, a2, a3, a4, t, d0;
    reset = 1'b1;
    for (int i = 0; i < NI; i++) begin
      req_a[i] = 1'b0; wr_a[i] = 1'b0; size_a[i] = 2'd2; strb_a[i] = 4'h0;
      addr_a[i] = '0; wdata_a[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    tick(0);
    tick(0);
    reset = 1'b0;

    // Instance 0: word write then read back-to-back, byte merge, alias read.
    dok_cyc.delete();
    t = cyc;
    issue(0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, a1);
    issue(0, 1'b0, 32'h100, 32'h0, 4'h0, a2);
    idle(0, 3);
    check("wr_accept_cycle", 32'(a1), 32'(t));
    check("rd_accept_cycle", 32'(a2), 32'(t + 1));
    check("wr_done_cycle", 32'(dc(0)), 32'(t + 1));
    check("rd_done_cycle", 32'(dc(1)), 32'(t + 2));
    check("rd_word", last_rd, 32'hDEADBEEF);
    issue(0, 1'b1, 32'h102, 32'h55555555, 4'h4, a1);
    issue(0, 1'b0, 32'h100, 32'h0, 4'h0, a1);
    idle(0, 3);
    check("rd_byte_merge", last_rd, 32'hDE55BEEF);
    issue(0, 1'b0, 32'hABCD0103, 32'h0, 4'h0, a1);
    idle(0, 3);
    check("rd_alias_0x103", last_rd, 32'hDE55BEEF);
    rand_phase(0, 120);

    // Instance 1: accept after two held cycles; withdrawn request is harmless.
    t = cyc;
    issue(1, 1'b1, 32'h40, 32'h12345678, 4'hF, a1);
    check("delay_accept_cycle", 32'(a1), 32'(t + 2));
    idle(1, 2);
    d0 = dok_cnt;
    t = cyc;
    req_a[1] = 1'b1; wr_a[1] = 1'b1; addr_a[1] = 32'h44; wdata_a[1] = 32'h00000BAD; strb_a[1] = 4'hF;
    tick(1);
    tick(1);
    req_a[1] = 1'b0;
    tick(1);
    issue(1, 1'b0, 32'h40, 32'h0, 4'h0, a1);
    idle(1, 3);
    check("reassert_accept_cycle", 32'(a1), 32'(t + 5));
    check("withdraw_done_count", 32'(dok_cnt - d0), 32'd1);
    check("withdraw_rd_word", last_rd, 32'h12345678);
    rand_phase(1, 80);

    // Instance 2: full queue stall and push-with-pop.
    issue(2, 1'b1, 32'h10, 32'hCAFE0001, 4'hF, a1);
    issue(2, 1'b1, 32'h14, 32'hCAFE0002, 4'hF, a1);
    idle(2, 6);
    dok_cyc.delete();
    issue(2, 1'b0, 32'h10, 32'h0, 4'h0, a1);
    issue(2, 1'b0, 32'h14, 32'h0, 4'h0, a2);
    issue(2, 1'b0, 32'h10, 32'h0, 4'h0, a3);
    idle(2, 8);
    check("full_second_accept", 32'(a2), 32'(a1 + 1));
    check("full_third_accept", 32'(a3), 32'(a1 + 3));
    check("full_done0", 32'(dc(0)), 32'(a1 + 3));
    check("full_done1", 32'(dc(1)), 32'(a1 + 4));
    check("full_done2", 32'(dc(2)), 32'(a1 + 6));
    check("full_last_rd", last_rd, 32'hCAFE0001);
    rand_phase(2, 100);

    // Instance 3: reset with reads in flight.
    issue(3, 1'b1, 32'h80, 32'hA5A5F00D, 4'hF, a1);
    idle(3, 6);
    d0 = dok_cnt;
    issue(3, 1'b0, 32'h80, 32'h0, 4'h0, a1);
    issue(3, 1'b0, 32'h80, 32'h0, 4'h0, a2);
    addr_a[3] = 32'h84;
    reset = 1'b1;
    tick(3);
    check("addr_ok_in_reset", {31'b0, obs_aok}, 32'd0);
    reset = 1'b0;
    idle(3, 8);
    check("no_done_after_reset", 32'(dok_cnt - d0), 32'd0);
    issue(3, 1'b0, 32'h80, 32'h0, 4'h0, a1);
    idle(3, 6);
    check("post_reset_rd", last_rd, 32'hA5A5F00D);
    issue(3, 1'b0, 32'h80, 32'h0, 4'h0, a1);
    issue(3, 1'b0, 32'h80, 32'h0, 4'h0, a2);
    issue(3, 1'b0, 32'h80, 32'h0, 4'h0, a3);
    issue(3, 1'b0, 32'h80, 32'h0, 4'h0, a4);
    idle(3, 8);
    check("post_reset_burst", 32'(a4 - a1), 32'd3);
    rand_phase(3, 120);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/data_sram_like_responder.md
Name: data_sram_like_responder

Overview:
- Responder (slave) end of the data-side SRAM-like interface (req/wr/size/wstrb/addr/wdata → addr_ok/data_ok/rdata) that the MEM stage drives as initiator.
- Backs the interface with an internal word-organised memory.
- Supports a programmable address-accept delay, a programmable data-return latency and a bounded number of in-order outstanding transactions.
- Used as the data-memory model in core-level simulation, and as an on-chip scratch RAM on FPGA builds without the AXI bridge.

Parameters:
- MEM_AW, 14: log2 of memory depth in 32-bit words; memory index is addr[MEM_AW+1:2], upper addr bits ignored.
- ADDR_DELAY, 0: number of cycles req must be held continuously before addr_ok is asserted (0 means same-cycle accept).
- DATA_DELAY, 1: cycles from the addr_ok handshake to data_ok for that transaction; legal range 1..15.
- OUTSTANDING, 2: maximum accepted-but-unanswered transactions; legal range 1..4.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req  in  1  request valid from initiator.
- wr  in  1  1 = write, 0 = read; qualified by req.
- size  in  2  0 = byte, 1 = half, 2 = word; informational only, wstrb governs writes.
- wstrb  in  4  byte write enables for writes.
- addr  in  32  byte address.
- wdata  in  32  write data, already lane-replicated by the initiator.
- addr_ok  out  1  request accepted this cycle (handshake = req && addr_ok).
- data_ok  out  1  one-cycle pulse; oldest outstanding transaction completes.
- rdata  out  32  read word, valid only when data_ok; 0 for write completions.

Behaviour:
- Reset (synchronous): addr_ok=0, data_ok=0, rdata=0, queue emptied, delay counters cleared. Memory contents are not reset; simulation initial content is all zeros.
- Accept condition:
  - addr_ok = req && (wait_cnt == ADDR_DELAY) && (count < OUTSTANDING || pop_this_cycle). This is combinational.
  - wait_cnt increments each cycle req is high and not accepted, saturating at ADDR_DELAY.
  - wait_cnt clears on accept or when req is low.
- Request withdrawal: the initiator may drop req before addr_ok (branch flush). No side effect; wait_cnt restarts from 0.
- At handshake in cycle t:
  - Writes update memory in cycle t for each byte with wstrb[i]=1; addr[1:0] is ignored.
  - Reads sample mem[index] in cycle t, so a write accepted earlier is always visible.
  - A read and a write are never accepted in the same cycle (one request per cycle).
  - An entry {is_read, data, cnt = DATA_DELAY-1} is pushed into the in-order queue; it is valid from cycle t+1.
- Countdown: each valid entry with cnt > 0 decrements every cycle.
- Completion:
  - data_ok = head valid && head cnt == 0, asserted one cycle, registered so it is glitch-free.
  - rdata = head data if is_read, else 0.
  - The head is popped in the same cycle.
  - Minimum latency is one cycle (DATA_DELAY=1: handshake at t, data_ok at t+1).
- Ordering: completions are strictly in acceptance order. A younger entry whose cnt reaches 0 waits (at 0) until it becomes head.
- Back-to-back: one accept and one completion per cycle max. Sustained throughput is 1 transaction/cycle when DATA_DELAY ≤ OUTSTANDING.
- Full queue:
  - count == OUTSTANDING with no pop → addr_ok=0 and req stalls.
  - Push and pop in the same cycle is allowed when full.
- Empty queue: data_ok=0 and rdata=0.
- Reset mid-operation: all outstanding transactions are discarded, with no data_ok for them. Writes already accepted remain in memory.
- Queue count width is clog2(OUTSTANDING+1); the pointer wraps modulo OUTSTANDING.

Test Plan:
- Default params, write addr=0x100 wdata=0xDEADBEEF wstrb=0xF at t; read 0x100 at t+1:
  - addr_ok at t and t+1, data_ok at t+1 (rdata=0) and t+2 (rdata=0xDEADBEEF).
- Byte write addr=0x102 wdata=0x55555555 wstrb=0x4 over 0xDEADBEEF, then read 0x100 → rdata=0xDE55BEEF; read 0x103 → same word 0xDE55BEEF.
- ADDR_DELAY=2: req held from t → addr_ok first at t+2. Separately, req high at t, t+1 then low at t+2, then re-asserted at t+3 → addr_ok at t+5 and no transaction from the withdrawn request.
- DATA_DELAY=3, OUTSTANDING=2, reads accepted at t and t+1:
  - A third req at t+2 is stalled; data_ok at t+3 and t+4 in order.
  - Third request accepted at t+3 (push with pop); its data_ok at t+6.
- Reset asserted one cycle after two reads are accepted (DATA_DELAY=4) → no data_ok afterwards, addr_ok=0 during reset, count=0. A fresh read after reset completes normally with its original memory data.
